piso_serializer: RTL and testbench

- Parallel-in serial-out transmitter. It is the send end of the 1-bit serial link whose receive end is the team's 4-bit SIPO shift register.
- Accepts a WIDTH-bit word over a ready/valid load handshake and emits it one bit per enabled clock, LSB first.
- With LSB_FIRST=1, a SIPO receiver clocked on the same edges holds the original word after WIDTH shifts.
- Supports gapless back-to-back words and a stall input.

---
 rtl/piso_serializer_pkg.sv | 13 +
 rtl/piso_serializer.sv | 96 +++++++++
 tb/tb_piso_serializer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in serial-out transmitter.
// State encodings are plain constants so legacy code can match on them.
package piso_serializer_pkg;

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StShift = 1'b1;

    // Bit counter width for a given word width.
    function automatic int unsigned cnt_w(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// Ready/valid loaded shift register that emits a word one bit per enabled cycle.
// Back-to-back words reload on the last bit so the serial stream has no bubble.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             en,
    output logic             sout,
    output logic             sout_valid,
    output logic             done
);

    localparam int unsigned     CntW    = cnt_w(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_shifted;
    logic             last;
    logic             accept;

    always_comb begin
        last       = (state_q == StShift) && (cnt_q == CntLast);
        done       = last && en;
        // Gated by reset so nothing is offered while the block is held in reset.
        load_ready = reset && ((state_q == StIdle) || (last && en));
        accept     = load_valid && load_ready;
        sout       = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
        sout_valid = (state_q == StShift);
    end

    always_comb begin
        if (LSB_FIRST) begin
            shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
        end else begin
            shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    shreg_d = load_data;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (en) begin
                    if (last) begin
                        cnt_d = '0;
                        if (accept) begin
                            shreg_d = load_data;
                        end else begin
                            shreg_d = '0;
                            state_d = StIdle;
                        end
                    end else begin
                        cnt_d   = cnt_q + CntW'(1);
                        shreg_d = shreg_shifted;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                shreg_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: LSB-first and MSB-first instances,
// with a 4-bit SIPO loopback sink on the LSB-first stream.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_valid, en;
    logic [3:0] load_data;
    logic       load_ready, sout, sout_valid, done;
    logic       lv_b, en_b;
    logic [3:0] ld_b;
    logic       lr_b, sout_b, sv_b, done_b;
    logic [3:0] sipo_q;

    int   checks = 0;
    int   errors = 0;
    logic exp_q[$];
    logic exp_bit;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .en         (en),
        .sout       (sout),
        .sout_valid (sout_valid),
        .done       (done)
    );

    piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b0)) u_dut_msb (
        .clk        (clk),
        .reset      (reset),
        .load_valid (lv_b),
        .load_ready (lr_b),
        .load_data  (ld_b),
        .en         (en_b),
        .sout       (sout_b),
        .sout_valid (sv_b),
        .done       (done_b)
    );

    // Receiver model: shifts in at the MSB end, clocked only on frame bits.
    always @(posedge clk or negedge reset) begin
        if (!reset) sipo_q <= 4'b0000;
        else if (en && sout_valid) sipo_q <= {sout, sipo_q[3:1]};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [3:0] w, input bit lsb_first);
        for (int i = 0; i < 4; i++) exp_q.push_back(lsb_first ? w[i] : w[3-i]);
    endtask

    task automatic test_reset();
        reset = 1'b0; load_valid = 1'b1; load_data = 4'b1111; en = 1'b1;
        lv_b = 1'b0; ld_b = 4'b0000; en_b = 1'b1;
        #1;
        step(); step();
        @(negedge clk);
        checks++;
        if ({load_ready, sout, sout_valid, done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0000", {load_ready, sout, sout_valid, done});
        end
        step();
        reset = 1'b1; load_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (load_ready !== 1'b1 || sout_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got ready=%b valid=%b want 1 0", load_ready, sout_valid);
        end
    endtask

    task automatic test_single();
        step();
        load_valid = 1'b1; load_data = 4'b1011;
        push_word(4'b1011, 1'b1);
        step();
        load_valid = 1'b0; load_data = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp_bit = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
            checks++;
            if (sout !== exp_bit || sout_valid !== 1'b1 || done !== (i == 3)) begin
                errors++;
                $display("FAIL single_bit%0d got sout=%b valid=%b done=%b want %b 1 %b",
                         i, sout, sout_valid, done, exp_bit, (i == 3));
            end
            step();
        end
        @(negedge clk);
        checks++;
        if (sout_valid !== 1'b0 || load_ready !== 1'b1 || sout !== 1'b0 || sipo_q !== 4'b1011) begin
            errors++;
            $display("FAIL single_end got valid=%b ready=%b sout=%b sipo=%b want 0 1 0 1011",
                     sout_valid, load_ready, sout, sipo_q);
        end
    endtask

    task automatic test_back_to_back();
        step();
        load_valid = 1'b1; load_data = 4'b1011;
        push_word(4'b1011, 1'b1);
        push_word(4'b0110, 1'b1);
        step();
        load_data = 4'b0110;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            exp_bit = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
            checks++;
            if (sout !== exp_bit || sout_valid !== 1'b1 || done !== (i == 3 || i == 7) ||
                load_ready !== (i == 3 || i == 7)) begin
                errors++;
                $display("FAIL b2b_bit%0d got sout=%b valid=%b done=%b ready=%b want %b 1 %b %b",
                         i, sout, sout_valid, done, load_ready, exp_bit,
                         (i == 3 || i == 7), (i == 3 || i == 7));
            end
            step();
            if (i == 3) load_valid = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (sout_valid !== 1'b0 || sipo_q !== 4'b0110) begin
            errors++;
            $display("FAIL b2b_end got valid=%b sipo=%b want 0 0110", sout_valid, sipo_q);
        end
    endtask

    task automatic test_stall();
        step();
        load_valid = 1'b1; load_data = 4'b1001;
        push_word(4'b1001, 1'b1);
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            exp_bit = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
            checks++;
            if (sout !== exp_bit || done !== 1'b0) begin
                errors++;
                $display("FAIL stall_pre%0d got sout=%b done=%b want %b 0", i, sout, done, exp_bit);
            end
            step();
        end
        // Offer a conflicting word during the stall; it must not be captured.
        en = 1'b0; load_valid = 1'b1; load_data = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exp_bit = (exp_q.size() > 0) ? exp_q[0] : 1'bx;
            checks++;
            if (sout !== exp_bit || sout_valid !== 1'b1 || done !== 1'b0 || load_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d got sout=%b valid=%b done=%b ready=%b want %b 1 0 0",
                         i, sout, sout_valid, done, load_ready, exp_bit);
            end
            step();
        end
        en = 1'b1; load_valid = 1'b0; load_data = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            exp_bit = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
            checks++;
            if (sout !== exp_bit || done !== (i == 1)) begin
                errors++;
                $display("FAIL stall_post%0d got sout=%b done=%b want %b %b",
                         i, sout, done, exp_bit, (i == 1));
            end
            step();
        end
        @(negedge clk);
        checks++;
        if (sout_valid !== 1'b0 || sipo_q !== 4'b1001) begin
            errors++;
            $display("FAIL stall_end got valid=%b sipo=%b want 0 1001", sout_valid, sipo_q);
        end
    endtask

    task automatic test_mid_reset();
        step();
        load_valid = 1'b1; load_data = 4'b1111;
        push_word(4'b1111, 1'b1);
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            exp_bit = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
            checks++;
            if (sout !== exp_bit) begin
                errors++;
                $display("FAIL midrst_pre%0d got sout=%b want %b", i, sout, exp_bit);
            end
            step();
        end
        #2 reset = 1'b0;
        #1;
        exp_q.delete();
        checks++;
        if (sout !== 1'b0 || sout_valid !== 1'b0 || done !== 1'b0 || load_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async got sout=%b valid=%b done=%b ready=%b want 0 0 0 0",
                     sout, sout_valid, done, load_ready);
        end
        step();
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || sout_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_hold got done=%b valid=%b want 0 0", done, sout_valid);
        end
        step();
        reset = 1'b1;
        load_valid = 1'b1; load_data = 4'b0101;
        push_word(4'b0101, 1'b1);
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp_bit = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
            checks++;
            if (sout !== exp_bit || sout_valid !== 1'b1 || done !== (i == 3)) begin
                errors++;
                $display("FAIL midrst_new%0d got sout=%b valid=%b done=%b want %b 1 %b",
                         i, sout, sout_valid, done, exp_bit, (i == 3));
            end
            step();
        end
        @(negedge clk);
        checks++;
        if (sipo_q !== 4'b0101) begin
            errors++;
            $display("FAIL midrst_sipo got %b want 0101", sipo_q);
        end
    endtask

    task automatic test_msb_first();
        step();
        lv_b = 1'b1; ld_b = 4'b1011;
        push_word(4'b1011, 1'b0);
        step();
        lv_b = 1'b0; ld_b = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp_bit = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
            checks++;
            if (sout_b !== exp_bit || sv_b !== 1'b1 || done_b !== (i == 3)) begin
                errors++;
                $display("FAIL msb_bit%0d got sout=%b valid=%b done=%b want %b 1 %b",
                         i, sout_b, sv_b, done_b, exp_bit, (i == 3));
            end
            step();
        end
        @(negedge clk);
        checks++;
        if (sv_b !== 1'b0 || lr_b !== 1'b1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL msb_end got valid=%b ready=%b left=%0d want 0 1 0",
                     sv_b, lr_b, exp_q.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_mid_reset();
        test_msb_first();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
